// File: rtl/fir_coeff_loader_pkg.sv
// Shared constants for the FIR coefficient loader: command fields, opcodes,
// status layout and the sequencer state encoding.
package fir_coeff_loader_pkg;

    localparam int unsigned CMD_TOG_BIT  = 31;
    localparam int unsigned CMD_OP_LSB   = 28;
    localparam int unsigned CMD_OP_W     = 3;
    localparam int unsigned CMD_ADDR_LSB = 18;
    localparam int unsigned CMD_ADDR_W   = 10;
    localparam int unsigned CMD_COEF_LSB = 0;
    localparam int unsigned CMD_COEF_W   = 18;

    localparam int unsigned ST_BUSY_BIT  = 31;
    localparam int unsigned ST_PEND_BIT  = 30;
    localparam int unsigned ST_OVF_BIT   = 29;
    localparam int unsigned ST_ILL_BIT   = 28;
    localparam int unsigned ST_CNT_W     = 16;

    typedef logic [CMD_OP_W-1:0] opcode_t;

    localparam opcode_t OP_NOP        = 3'b000;
    localparam opcode_t OP_WRITE      = 3'b001;
    localparam opcode_t OP_COMMIT     = 3'b010;
    localparam opcode_t OP_CLEAR      = 3'b011;
    localparam opcode_t OP_CLR_STATUS = 3'b100;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StClear,
        StWaitSync
    } state_e;

endpackage

// File: rtl/fir_coeff_loader_if.sv
// Command, tap-RAM write port and status signals of the coefficient loader.
interface fir_coeff_loader_if #(
    parameter int unsigned TAP_AW = 7,
    parameter int unsigned COEF_W = 18
);
    logic [31:0]       sw_cmd;
    logic              sync_in;
    logic              wr_valid;
    logic              wr_ready;
    logic [TAP_AW:0]   wr_addr;
    logic [COEF_W-1:0] wr_data;
    logic              active_bank;
    logic [31:0]       status;

    modport master (
        input  sw_cmd, sync_in, wr_ready,
        output wr_valid, wr_addr, wr_data, active_bank, status
    );

    modport slave (
        output sw_cmd, sync_in, wr_ready,
        input  wr_valid, wr_addr, wr_data, active_bank, status
    );
endinterface

// File: rtl/fir_cmd_toggle_detect.sv
// Stages the software command word and flags a new command whenever its
// toggle bit differs from the previously staged value.
module fir_cmd_toggle_detect
    import fir_coeff_loader_pkg::*;
#(
    parameter int unsigned TAP_AW = 7,
    parameter int unsigned COEF_W = 18
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [31:0]       sw_cmd_i,
    output logic              cmd_stb_o,
    output opcode_t           cmd_op_o,
    output logic [TAP_AW-1:0] cmd_addr_o,
    output logic [COEF_W-1:0] cmd_coef_o
);

    logic [31:0] cmd_q;
    logic        prev_tog_q;
    logic        cmd_vld_q;
    logic        primed_q;

    // cmd_vld_q marks cmd_q as holding a real sample; primed_q then lets the
    // toggle history catch up once before any command can be detected.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_q      <= '0;
            prev_tog_q <= 1'b0;
            cmd_vld_q  <= 1'b0;
            primed_q   <= 1'b0;
        end else begin
            cmd_q      <= sw_cmd_i;
            prev_tog_q <= cmd_q[CMD_TOG_BIT];
            cmd_vld_q  <= 1'b1;
            primed_q   <= cmd_vld_q;
        end
    end

    assign cmd_stb_o  = primed_q & (cmd_q[CMD_TOG_BIT] ^ prev_tog_q);
    assign cmd_op_o   = cmd_q[CMD_OP_LSB +: CMD_OP_W];
    assign cmd_addr_o = cmd_q[CMD_ADDR_LSB +: TAP_AW];
    assign cmd_coef_o = cmd_q[CMD_COEF_LSB +: COEF_W];

    logic unused_cmd_bits;
    assign unused_cmd_bits = ^cmd_q;

endmodule

// File: rtl/fir_coeff_loader.sv
// Loads FIR taps into the shadow bank of a double-buffered tap RAM and swaps
// banks only on a frame sync; reports progress through a status word.
module fir_coeff_loader
    import fir_coeff_loader_pkg::*;
#(
    parameter int unsigned TAP_AW = 7,
    parameter int unsigned COEF_W = 18
) (
    input logic                user_clk,
    input logic                user_rst_n,
    fir_coeff_loader_if.master bus
);

    logic              cmd_stb;
    opcode_t           cmd_op;
    logic [TAP_AW-1:0] cmd_addr;
    logic [COEF_W-1:0] cmd_coef;

    fir_cmd_toggle_detect #(
        .TAP_AW (TAP_AW),
        .COEF_W (COEF_W)
    ) u_detect (
        .clk_i      (user_clk),
        .rst_ni     (user_rst_n),
        .sw_cmd_i   (bus.sw_cmd),
        .cmd_stb_o  (cmd_stb),
        .cmd_op_o   (cmd_op),
        .cmd_addr_o (cmd_addr),
        .cmd_coef_o (cmd_coef)
    );

    state_e            state_q, state_d;
    logic              wr_valid_q, wr_valid_d;
    logic [TAP_AW:0]   wr_addr_q, wr_addr_d;
    logic [COEF_W-1:0] wr_data_q, wr_data_d;
    logic              bank_q, bank_d;
    logic [15:0]       count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              ill_q, ill_d;
    logic              accept;

    assign accept = wr_valid_q & bus.wr_ready;

    always_comb begin
        state_d    = state_q;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        bank_d     = bank_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        ill_d      = ill_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_stb) begin
                    case (cmd_op)
                        OP_NOP: count_d = count_q + 16'd1;
                        OP_WRITE: begin
                            state_d    = StWrite;
                            wr_valid_d = 1'b1;
                            wr_addr_d  = {~bank_q, cmd_addr};
                            wr_data_d  = cmd_coef;
                        end
                        OP_COMMIT: state_d = StWaitSync;
                        OP_CLEAR: begin
                            state_d    = StClear;
                            wr_valid_d = 1'b1;
                            wr_addr_d  = {~bank_q, {TAP_AW{1'b0}}};
                            wr_data_d  = '0;
                        end
                        OP_CLR_STATUS: begin
                            ovf_d   = 1'b0;
                            ill_d   = 1'b0;
                            count_d = '0;
                        end
                        default: ill_d = 1'b1;
                    endcase
                end
            end
            StWrite: begin
                if (accept) begin
                    wr_valid_d = 1'b0;
                    count_d    = count_q + 16'd1;
                    state_d    = StIdle;
                end
            end
            StClear: begin
                if (accept) begin
                    if (&wr_addr_q[TAP_AW-1:0]) begin
                        wr_valid_d = 1'b0;
                        count_d    = count_q + 16'd1;
                        state_d    = StIdle;
                    end else begin
                        wr_addr_d = {wr_addr_q[TAP_AW], wr_addr_q[TAP_AW-1:0] + 1'b1};
                    end
                end
            end
            StWaitSync: begin
                if (bus.sync_in) begin
                    bank_d    = ~bank_q;
                    // Keep the write-address bank bit pointing at the new shadow bank.
                    wr_addr_d = {bank_q, wr_addr_q[TAP_AW-1:0]};
                    count_d   = count_q + 16'd1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (cmd_stb && (state_q != StIdle)) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q    <= StIdle;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            bank_q     <= 1'b0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            ill_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            bank_q     <= bank_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            ill_q      <= ill_d;
        end
    end

    always_comb begin
        bus.status                 = '0;
        bus.status[ST_BUSY_BIT]    = (state_q != StIdle);
        bus.status[ST_PEND_BIT]    = (state_q == StWaitSync);
        bus.status[ST_OVF_BIT]     = ovf_q;
        bus.status[ST_ILL_BIT]     = ill_q;
        bus.status[ST_CNT_W-1:0]   = count_q;
    end

    assign bus.wr_valid    = wr_valid_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.active_bank = bank_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader: vector table for single commands plus
// hand-written sequences for throttled CLEAR, COMMIT, overflow and reset.
module tb_fir_coeff_loader;

    localparam logic [2:0] C_NOP    = 3'b000;
    localparam logic [2:0] C_WRITE  = 3'b001;
    localparam logic [2:0] C_COMMIT = 3'b010;
    localparam logic [2:0] C_CLEAR  = 3'b011;
    localparam logic [2:0] C_CLRST  = 3'b100;
    localparam int NVEC = 8;

    typedef struct {
        logic [2:0]  op;
        logic [9:0]  addr;
        logic [17:0] coef;
        logic        exp_valid;
        logic [7:0]  exp_addr;
        logic [17:0] exp_data;
        logic [31:0] exp_status;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tog = 1'b1;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs [NVEC];

    fir_coeff_loader_if #(.TAP_AW(7), .COEF_W(18)) bus ();

    fir_coeff_loader #(.TAP_AW(7), .COEF_W(18)) dut (
        .user_clk   (clk),
        .user_rst_n (rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [9:0] a, input logic [17:0] c);
        tog = ~tog;
        bus.sw_cmd = {tog, op, a, c};
    endtask

    initial begin
        int   beats;
        int   ord_err;
        int   hold_err;
        int   cyc;
        int   wait_err;
        logic r;
        logic [7:0] exp_a;

        vecs[0] = '{C_WRITE, 10'h000, 18'h3FFFF, 1'b1, 8'h80, 18'h3FFFF, 32'h0000_0002};
        vecs[1] = '{C_WRITE, 10'h07F, 18'h00001, 1'b1, 8'hFF, 18'h00001, 32'h0000_0003};
        vecs[2] = '{C_WRITE, 10'h205, 18'h25555, 1'b1, 8'h85, 18'h25555, 32'h0000_0004};
        vecs[3] = '{C_NOP,   10'h000, 18'h00000, 1'b0, 8'h00, 18'h00000, 32'h0000_0005};
        vecs[4] = '{3'b101,  10'h011, 18'h00022, 1'b0, 8'h00, 18'h00000, 32'h1000_0005};
        vecs[5] = '{3'b111,  10'h000, 18'h00000, 1'b0, 8'h00, 18'h00000, 32'h1000_0005};
        vecs[6] = '{C_CLRST, 10'h000, 18'h00000, 1'b0, 8'h00, 18'h00000, 32'h0000_0000};
        vecs[7] = '{C_NOP,   10'h000, 18'h00000, 1'b0, 8'h00, 18'h00000, 32'h0000_0001};

        bus.sw_cmd   = 32'h8000_0000;
        bus.sync_in  = 1'b0;
        bus.wr_ready = 1'b0;

        // Reset with the toggle bit parked high: nothing may fire.
        repeat (3) tick();
        check("reset status", bus.status, 32'h0);
        check("reset wr_valid", 32'(bus.wr_valid), 32'h0);
        check("reset wr_addr", 32'(bus.wr_addr), 32'h0);
        check("reset wr_data", 32'(bus.wr_data), 32'h0);
        rst_n = 1'b1;
        repeat (10) tick();
        check("primed status", bus.status, 32'h0);
        check("primed wr_valid", 32'(bus.wr_valid), 32'h0);

        // WRITE with backpressure.
        issue(C_WRITE, 10'd5, 18'h1ABCD);
        tick();
        check("write early valid", 32'(bus.wr_valid), 32'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("write stall valid", 32'(bus.wr_valid), 32'h1);
            check("write stall addr", 32'(bus.wr_addr), 32'h85);
            check("write stall data", 32'(bus.wr_data), 32'h1ABCD);
            check("write stall busy", 32'(bus.status[31]), 32'h1);
            tick();
        end
        bus.wr_ready = 1'b1;
        check("write held valid", 32'(bus.wr_valid), 32'h1);
        tick();
        check("write done valid", 32'(bus.wr_valid), 32'h0);
        check("write done status", bus.status, 32'h0000_0001);

        // Table of single commands with wr_ready high.
        for (int i = 0; i < NVEC; i++) begin
            issue(vecs[i].op, vecs[i].addr, vecs[i].coef);
            tick();
            tick();
            check($sformatf("vec%0d wr_valid", i), 32'(bus.wr_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d wr_addr", i), 32'(bus.wr_addr), 32'(vecs[i].exp_addr));
                check($sformatf("vec%0d wr_data", i), 32'(bus.wr_data), 32'(vecs[i].exp_data));
            end
            tick();
            check($sformatf("vec%0d status", i), bus.status, vecs[i].exp_status);
        end

        // CLEAR with random throttling.
        bus.wr_ready = 1'b0;
        issue(C_CLEAR, 10'h0, 18'h0);
        tick();
        tick();
        beats = 0; ord_err = 0; hold_err = 0; cyc = 0;
        while (beats < 128 && cyc < 2000) begin
            r = 1'($urandom_range(0, 1));
            bus.wr_ready = r;
            if (bus.wr_valid !== 1'b1 || bus.status[31] !== 1'b1) begin
                hold_err++;
            end else if (r) begin
                exp_a = 8'h80 + 8'(beats);
                if (bus.wr_addr !== exp_a || bus.wr_data !== 18'h0) ord_err++;
                beats++;
            end
            tick();
            cyc++;
        end
        check("clear beats", 32'(beats), 32'd128);
        check("clear order", 32'(ord_err), 32'd0);
        check("clear hold/busy", 32'(hold_err), 32'd0);
        check("clear done valid", 32'(bus.wr_valid), 32'h0);
        check("clear done status", bus.status, 32'h0000_0002);

        // COMMIT with a sync coincident with detection (ignored), real sync later.
        bus.wr_ready = 1'b1;
        issue(C_COMMIT, 10'h0, 18'h0);
        tick();
        bus.sync_in = 1'b1;
        tick();
        bus.sync_in = 1'b0;
        check("commit pending status", bus.status, 32'hC000_0002);
        check("commit early bank", 32'(bus.active_bank), 32'h0);
        wait_err = 0;
        repeat (19) begin
            tick();
            if (bus.status[30] !== 1'b1 || bus.active_bank !== 1'b0) wait_err++;
        end
        check("commit wait", 32'(wait_err), 32'd0);
        bus.sync_in = 1'b1;
        tick();
        bus.sync_in = 1'b0;
        check("commit bank", 32'(bus.active_bank), 32'h1);
        check("commit status", bus.status, 32'h0000_0003);
        issue(C_WRITE, 10'd3, 18'h00007);
        tick();
        tick();
        check("bank0 write addr", 32'(bus.wr_addr), 32'h03);
        check("bank0 write data", 32'(bus.wr_data), 32'h7);
        tick();
        check("bank0 write status", bus.status, 32'h0000_0004);

        // Overflow during CLEAR, then an illegal opcode, then CLR_STATUS.
        issue(C_CLEAR, 10'h0, 18'h0);
        tick();
        tick();
        issue(C_NOP, 10'h0, 18'h0);
        cyc = 0;
        while (bus.wr_valid === 1'b1 && cyc < 400) begin
            tick();
            cyc++;
        end
        check("ovf clear ended", 32'(bus.wr_valid), 32'h0);
        check("ovf status", bus.status, 32'h2000_0005);
        issue(3'b110, 10'h0, 18'h0);
        repeat (3) tick();
        check("illegal status", bus.status, 32'h3000_0005);
        issue(C_CLRST, 10'h0, 18'h0);
        repeat (3) tick();
        check("clr_status", bus.status, 32'h0);

        // Reset in WAIT_SYNC with sync pulsing during and after reset.
        issue(C_COMMIT, 10'h0, 18'h0);
        tick();
        tick();
        check("pre-reset pending", bus.status, 32'hC000_0000);
        rst_n = 1'b0;
        #1;
        check("async reset bank", 32'(bus.active_bank), 32'h0);
        check("async reset status", bus.status, 32'h0);
        bus.sync_in = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        bus.sync_in = 1'b0;
        repeat (5) tick();
        check("post-reset bank", 32'(bus.active_bank), 32'h0);
        check("post-reset status", bus.status, 32'h0);
        check("post-reset wr_valid", 32'(bus.wr_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
